pingpong_dpram_buf: RTL and testbench
=====================================

PINGPONG_DPRAM_BUF -- requirements
Module: pingpong_dpram_buf

Interface
REQ-001 Parameter DWIDTH, default 60, data word width in bits.
REQ-002 Parameter AWIDTH, default 12, address width per bank.
REQ-003 Parameter NUM_WORDS, default 4096, words per bank, at most 2**AWIDTH.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  producer write strobe.
REQ-007 wr_addr  input  AWIDTH  producer write address.
REQ-008 wr_data  input  DWIDTH  producer write data.
REQ-009 prod_commit  input  1  producer finished filling the current bank.
REQ-010 commit_len  input  AWIDTH+1  valid word count of the committed bank.
REQ-011 prod_ready  output  1  producer bank is free and accepts writes and commits.
REQ-012 rd_addr_a, rd_addr_b  input  AWIDTH each  consumer read addresses, two independent ports.
REQ-013 rd_data_a, rd_data_b  output  DWIDTH each  registered read data.
REQ-014 cons_valid  output  1  consumer bank holds committed data.
REQ-015 cons_len  output  AWIDTH+1  commit_len captured for the consumer bank.
REQ-016 cons_release  input  1  consumer finished with the current bank.
REQ-017 wr_bank, rd_bank  output  1 each  current producer and consumer bank indices.
REQ-018 err_overrun  output  1  sticky: wr_en or prod_commit asserted while prod_ready=0.

Function
REQ-019 Two banks SHALL exist, each NUM_WORDS x DWIDTH, each with a full flag and a stored length.
REQ-020 prod_ready SHALL equal NOT full[wr_bank]; cons_valid SHALL equal full[rd_bank].
REQ-021 A write with wr_en=1 and prod_ready=1 SHALL store wr_data at wr_addr of bank wr_bank; writes with prod_ready=0 SHALL be dropped.
REQ-022 A commit with prod_commit=1 and prod_ready=1 SHALL set full[wr_bank], store commit_len (saturated to NUM_WORDS) as that bank's length, and toggle wr_bank, all in the same edge.
REQ-023 A write and a commit in the same cycle SHALL both take effect, the write landing in the bank being committed.
REQ-024 A release with cons_release=1 and cons_valid=1 SHALL clear full[rd_bank] and toggle rd_bank; a release with cons_valid=0 SHALL be ignored and SHALL NOT set err_overrun.
REQ-025 A commit and a release in the same cycle SHALL both take effect; with both banks full, the release SHALL raise prod_ready in the next cycle.
REQ-026 Reads SHALL have 1-cycle latency: rd_data_x at cycle n+1 SHALL be the word at rd_addr_x of the bank that was rd_bank at cycle n, bank select registered alongside the address.
REQ-027 Reads SHALL be performed every cycle regardless of cons_valid; data read while cons_valid=0 has no defined meaning.
REQ-028 cons_len SHALL show the stored length of bank rd_bank; it SHALL be 0 when cons_valid=0.
REQ-029 Writes at addresses >= NUM_WORDS SHALL be dropped.
REQ-030 err_overrun SHALL be set by either illegal event of REQ-018 and SHALL clear only on reset.

Reset
REQ-031 On reset: wr_bank=0, rd_bank=0, both full flags=0, both lengths=0, prod_ready=1, cons_valid=0, cons_len=0, rd_data_a=rd_data_b=0, err_overrun=0.
REQ-032 Reset SHALL NOT clear RAM contents; reset mid-fill SHALL discard both banks' fill status.
REQ-033 Inputs SHALL be ignored during any cycle in which reset=1.

Structure
REQ-034 A shared package SHALL hold the default DWIDTH, AWIDTH and NUM_WORDS constants and a bank-index typedef.
REQ-035 Each bank SHALL be one instance of a sub-module dpram_param (parameterised true dual-port RAM, registered outputs): port A is shared between producer write and consumer read A, muxed by bank role; port B is consumer read B.
REQ-036 Control (full flags, lengths, bank pointers, error) SHALL live in the top module; total RTL 120-400 lines.

Verification
REQ-037 Reset, write 0xA5 at addr 3, commit len 4 -> next cycle wr_bank=1, rd_bank=0, cons_valid=1, cons_len=4; read addr_a=3 -> rd_data_a=0xA5 one cycle later.
REQ-038 Fill and commit both banks without release -> prod_ready=0; further wr_en -> dropped, err_overrun=1; release -> prod_ready=1 next cycle.
REQ-039 Commit and release in the same cycle with one bank full -> both pointers toggle, cons_valid stays 1, cons_len shows the new bank's length.
REQ-040 commit_len=5000 with NUM_WORDS=4096 -> cons_len=4096; write at addr 4096 with AWIDTH=13 -> no RAM change.
REQ-041 Reset asserted with both banks full -> next cycle prod_ready=1, cons_valid=0, both pointers 0, err_overrun=0.
REQ-042 DWIDTH=16, AWIDTH=4, NUM_WORDS=16: 100 random commit/release cycles against a reference FIFO-of-banks model -> all read data and flags match.

Source files
------------

// File: rtl/pingpong_dpram_buf_pkg.sv
// Shared constants and types for the ping-pong dual-port RAM buffer.
package pingpong_dpram_buf_pkg;

  localparam int DEF_DWIDTH    = 60;
  localparam int DEF_AWIDTH    = 12;
  localparam int DEF_NUM_WORDS = 4096;

  typedef logic bank_t;

endpackage

// File: rtl/pingpong_dpram_buf_dpram.sv
// True dual-port RAM bank: port A read/write, port B read-only, both with registered outputs.
module dpram_param
  import pingpong_dpram_buf_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] wdata_a,
  output logic [DWIDTH-1:0] rdata_a,
  input  logic [AWIDTH-1:0] addr_b,
  output logic [DWIDTH-1:0] rdata_b
);

  logic [DWIDTH-1:0] mem_q [NUM_WORDS];
  logic [DWIDTH-1:0] rdata_a_q;
  logic [DWIDTH-1:0] rdata_b_q;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_q[addr_a] <= wdata_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= mem_q[addr_a];
      rdata_b_q <= mem_q[addr_b];
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/pingpong_dpram_buf.sv
// Two-bank ping-pong buffer: producer fills one bank while the consumer reads the other.
module pingpong_dpram_buf
  import pingpong_dpram_buf_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              prod_commit,
  input  logic [AWIDTH:0]   commit_len,
  output logic              prod_ready,
  input  logic [AWIDTH-1:0] rd_addr_a,
  input  logic [AWIDTH-1:0] rd_addr_b,
  output logic [DWIDTH-1:0] rd_data_a,
  output logic [DWIDTH-1:0] rd_data_b,
  output logic              cons_valid,
  output logic [AWIDTH:0]   cons_len,
  input  logic              cons_release,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err_overrun
);

  localparam logic [AWIDTH:0] NW_L = (AWIDTH + 1)'(NUM_WORDS);

  function automatic logic [AWIDTH:0] sat_len(input logic [AWIDTH:0] len);
    return (len > NW_L) ? NW_L : len;
  endfunction

  logic [1:0]      full_q, full_d;
  logic [AWIDTH:0] len_q [2];
  logic [AWIDTH:0] len_d [2];
  bank_t           wr_bank_q, wr_bank_d;
  bank_t           rd_bank_q, rd_bank_d;
  bank_t           rd_sel_q;
  logic            err_q, err_d;

  logic            prod_ready_w, cons_valid_w;
  logic            wr_ok, commit_ok, release_ok;

  assign prod_ready_w = ~full_q[wr_bank_q];
  assign cons_valid_w = full_q[rd_bank_q];

  assign wr_ok      = ~reset & wr_en & prod_ready_w & ({1'b0, wr_addr} < NW_L);
  assign commit_ok  = ~reset & prod_commit & prod_ready_w;
  assign release_ok = ~reset & cons_release & cons_valid_w;

  // Commit and release always target different banks (one empty, one full), so both may apply.
  always_comb begin
    full_d    = full_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = err_q;
    if (commit_ok) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = sat_len(commit_len);
      wr_bank_d         = ~wr_bank_q;
    end
    if (release_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (~reset & (wr_en | prod_commit) & ~prod_ready_w) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      len_q     <= len_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_sel_q  <= rd_bank_q;
      err_q     <= err_d;
    end
  end

  logic              bank_we     [2];
  logic [AWIDTH-1:0] bank_addr_a [2];
  logic [DWIDTH-1:0] bank_rdata_a[2];
  logic [DWIDTH-1:0] bank_rdata_b[2];

  // Port A serves the producer on the bank being written, otherwise consumer read A.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b]     = wr_ok & (wr_bank_q == bank_t'(b));
    assign bank_addr_a[b] = bank_we[b] ? wr_addr : rd_addr_a;

    dpram_param #(
      .DWIDTH   (DWIDTH),
      .AWIDTH   (AWIDTH),
      .NUM_WORDS(NUM_WORDS)
    ) u_ram (
      .clk    (clk),
      .reset  (reset),
      .we_a   (bank_we[b]),
      .addr_a (bank_addr_a[b]),
      .wdata_a(wr_data),
      .rdata_a(bank_rdata_a[b]),
      .addr_b (rd_addr_b),
      .rdata_b(bank_rdata_b[b])
    );
  end

  assign rd_data_a   = bank_rdata_a[rd_sel_q];
  assign rd_data_b   = bank_rdata_b[rd_sel_q];
  assign prod_ready  = prod_ready_w;
  assign cons_valid  = cons_valid_w;
  assign cons_len    = cons_valid_w ? len_q[rd_bank_q] : '0;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_pingpong_dpram_buf.sv
// Scoreboard bench for pingpong_dpram_buf: directed scenarios plus a modelled commit/release run.
module tb_pingpong_dpram_buf;

  localparam int DW = 60;
  localparam int AW = 13;
  localparam int NW = 4096;

  localparam int S_RDA = 0, S_RDB = 1, S_PR = 2, S_CV = 3, S_LEN = 4, S_WB = 5, S_RB = 6, S_ERR = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          prod_commit;
  logic [AW:0]   commit_len;
  logic          prod_ready;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          cons_valid;
  logic [AW:0]   cons_len;
  logic          cons_release;
  logic          wr_bank, rd_bank;
  logic          err_overrun;

  always #5 clk = ~clk;

  pingpong_dpram_buf #(.DWIDTH(DW), .AWIDTH(AW), .NUM_WORDS(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .prod_commit (prod_commit),
    .commit_len  (commit_len),
    .prod_ready  (prod_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .cons_valid  (cons_valid),
    .cons_len    (cons_len),
    .cons_release(cons_release),
    .wr_bank     (wr_bank),
    .rd_bank     (rd_bank),
    .err_overrun (err_overrun)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_RDA:   return 64'(rd_data_a);
      S_RDB:   return 64'(rd_data_b);
      S_PR:    return 64'(prod_ready);
      S_CV:    return 64'(cons_valid);
      S_LEN:   return 64'(cons_len);
      S_WB:    return 64'(wr_bank);
      S_RB:    return 64'(rd_bank);
      S_ERR:   return 64'(err_overrun);
      default: return 64'hdead_beef;
    endcase
  endfunction

  // Monitor: retires every expectation due after the most recent rising edge.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e   = sbq.pop_front();
        act = actual(e.sel);
        checks++;
        if (e.due != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (due cycle %0d, seen %0d)", e.nm, act, e.exp, e.due, cyc);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [63:0] v, input string nm);
    exp_t e;
    e.due = cyc + 1;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sbq.push_back(e);
  endtask

  task automatic chk_flags(input bit pr, input bit cv, input logic [AW:0] len, input bit wb,
                           input bit rb, input bit err, input string tag);
    expect_v(S_PR,  64'(pr),  {tag, ".prod_ready"});
    expect_v(S_CV,  64'(cv),  {tag, ".cons_valid"});
    expect_v(S_LEN, 64'(len), {tag, ".cons_len"});
    expect_v(S_WB,  64'(wb),  {tag, ".wr_bank"});
    expect_v(S_RB,  64'(rb),  {tag, ".rd_bank"});
    expect_v(S_ERR, 64'(err), {tag, ".err_overrun"});
  endtask

  task automatic idle();
    wr_en        = 1'b0;
    prod_commit  = 1'b0;
    cons_release = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  bit          m_full [2];
  logic [AW:0] m_len  [2];
  bit          m_wb, m_rb;
  logic [DW-1:0] m_mem [2][16];
  bit          m_known[2][16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int ra, rb2;
    bit rdy, cv;

    reset = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; commit_len = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) tick();

    // Reset state, with every input asserted to show it is ignored during reset.
    wr_en = 1'b1; wr_addr = 13'd3; wr_data = 60'h999; prod_commit = 1'b1; commit_len = 14'd1;
    cons_release = 1'b1;
    chk_flags(1, 0, 0, 0, 0, 0, "reset");
    expect_v(S_RDA, 64'h0, "reset.rd_data_a");
    expect_v(S_RDB, 64'h0, "reset.rd_data_b");
    tick(); reset = 1'b0; idle();

    // Write 0xA5 at 3 and commit length 4.
    wr_en = 1'b1; wr_addr = 13'd3; wr_data = 60'hA5; prod_commit = 1'b1; commit_len = 14'd4;
    chk_flags(1, 1, 4, 1, 0, 0, "commit1");
    tick(); idle();
    rd_addr_a = 13'd3; rd_addr_b = 13'd3;
    expect_v(S_RDA, 64'hA5, "rd1.a");
    expect_v(S_RDB, 64'hA5, "rd1.b");
    tick();

    // Fill second bank: both full, then an overrun write must be dropped.
    wr_en = 1'b1; wr_addr = 13'd7; wr_data = 60'h123; prod_commit = 1'b1; commit_len = 14'd8;
    chk_flags(0, 1, 4, 0, 0, 0, "both_full");
    tick(); idle();
    wr_en = 1'b1; wr_addr = 13'd3; wr_data = 60'hBAD;
    chk_flags(0, 1, 4, 0, 0, 1, "overrun");
    tick(); idle();
    rd_addr_a = 13'd3; cons_release = 1'b1;
    expect_v(S_RDA, 64'hA5, "drop.a");
    chk_flags(1, 1, 8, 0, 1, 1, "release1");
    tick(); idle();
    rd_addr_a = 13'd7; rd_addr_b = 13'd7;
    expect_v(S_RDA, 64'h123, "rd2.a");
    expect_v(S_RDB, 64'h123, "rd2.b");
    tick();

    // Commit (with a write) and release in one cycle.
    wr_en = 1'b1; wr_addr = 13'd3; wr_data = 60'h5A5A; prod_commit = 1'b1; commit_len = 14'd2;
    cons_release = 1'b1;
    chk_flags(1, 1, 2, 1, 0, 1, "commit_rel");
    tick(); idle();
    rd_addr_a = 13'd3; rd_addr_b = 13'd3;
    expect_v(S_RDA, 64'h5A5A, "rd3.a");
    expect_v(S_RDB, 64'h5A5A, "rd3.b");
    tick();

    // Length saturation and out-of-range write drop.
    wr_en = 1'b1; wr_addr = 13'd0; wr_data = 60'h11;
    tick();
    wr_en = 1'b1; wr_addr = 13'd4096; wr_data = 60'hDEAD;
    tick(); idle();
    prod_commit = 1'b1; commit_len = 14'd5000;
    chk_flags(0, 1, 2, 0, 0, 1, "commit_sat");
    tick(); idle();
    cons_release = 1'b1;
    chk_flags(1, 1, 4096, 0, 1, 1, "sat_len");
    tick(); idle();
    rd_addr_a = 13'd0; rd_addr_b = 13'd0;
    expect_v(S_RDA, 64'h11, "oob.a");
    expect_v(S_RDB, 64'h11, "oob.b");
    tick();

    // Reset with both banks full.
    prod_commit = 1'b1; commit_len = 14'd3;
    chk_flags(0, 1, 4096, 1, 1, 1, "full2");
    tick(); idle();
    reset = 1'b1;
    chk_flags(1, 0, 0, 0, 0, 0, "reset_full");
    expect_v(S_RDA, 64'h0, "reset_full.rd_a");
    tick(); reset = 1'b0;

    // Release with nothing valid is ignored and is not an error.
    cons_release = 1'b1;
    chk_flags(1, 0, 0, 0, 0, 0, "rel_empty");
    tick(); idle();

    // Modelled commit/release run on a 16-word address window.
    m_full = '{0, 0}; m_len = '{0, 0}; m_wb = 0; m_rb = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) m_known[b][a] = 0;
    for (int i = 0; i < 100; i++) begin
      rdy = !m_full[m_wb];
      cv  = m_full[m_rb];
      ra  = $urandom_range(15);
      rb2 = $urandom_range(15);
      wr_en        = rdy && ($urandom_range(1) == 1);
      wr_addr      = AW'($urandom_range(15));
      wr_data      = DW'({$urandom, $urandom});
      prod_commit  = rdy && ($urandom_range(3) == 0);
      commit_len   = (AW + 1)'($urandom_range(20));
      cons_release = cv && ($urandom_range(2) == 0);
      rd_addr_a    = AW'(ra);
      rd_addr_b    = AW'(rb2);
      if (cv && m_known[m_rb][ra])  expect_v(S_RDA, 64'(m_mem[m_rb][ra]), "rnd.rd_a");
      if (cv && m_known[m_rb][rb2]) expect_v(S_RDB, 64'(m_mem[m_rb][rb2]), "rnd.rd_b");
      if (wr_en) begin
        m_mem[m_wb][wr_addr[3:0]]   = wr_data;
        m_known[m_wb][wr_addr[3:0]] = 1;
      end
      if (prod_commit) begin
        m_full[m_wb] = 1;
        m_len[m_wb]  = commit_len;
        m_wb         = !m_wb;
      end
      if (cons_release) begin
        m_full[m_rb] = 0;
        m_rb         = !m_rb;
      end
      chk_flags(!m_full[m_wb], m_full[m_rb], m_full[m_rb] ? m_len[m_rb] : '0, m_wb, m_rb, 0, "rnd");
      tick();
    end
    idle();
    repeat (3) tick();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
